// File: rtl/crc_fifo_buffer.sv
// crc_fifo_buffer: NCH independent circular fingerprint FIFOs sharing one
// memory of NCH*DEPTH words. It has a registered pop port, per-channel
// full/empty status, per-channel flush, and sticky overflow/underflow flags.
module crc_fifo_buffer #(
  parameter int CW    = 32,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [CHW-1:0] rd_ch,
  output logic [CW-1:0]  rd_data,
  output logic           rd_valid,
  input  logic           flush,
  input  logic [CHW-1:0] flush_ch,
  input  logic           clr_err,
  output logic [NCH-1:0] full,
  output logic [NCH-1:0] empty,
  output logic [NCH-1:0] overflow,
  output logic [NCH-1:0] underflow
);

  localparam int          NW       = NCH * DEPTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Shared storage: the address is {channel, pointer}.
  logic [CW-1:0]  mem_q [NW];

  logic [AW-1:0]  wptr_q  [NCH];
  logic [AW-1:0]  wptr_d  [NCH];
  logic [AW-1:0]  rptr_q  [NCH];
  logic [AW-1:0]  rptr_d  [NCH];
  logic [AW:0]    count_q [NCH];
  logic [AW:0]    count_d [NCH];

  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] unf_q, unf_d;
  logic [CW-1:0]  rd_data_q;
  logic           rd_valid_q;

  logic           wr_flushed, rd_flushed;
  logic           wr_full, rd_empty;
  logic           push_ok, pop_ok;
  logic [NCH-1:0] ovf_ev, unf_ev;

  // Decide whether this cycle's push and pop are accepted. A flush on the
  // same channel suppresses both the operation and its error flag.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves a signal unassigned and no latch is inferred.
    ovf_ev     = '0;
    unf_ev     = '0;
    rd_flushed = flush && (flush_ch == rd_ch);
    wr_flushed = flush && (flush_ch == wr_ch);
    rd_empty   = (count_q[rd_ch] == '0);
    wr_full    = (count_q[wr_ch] == FULL_CNT);
    pop_ok     = rd_en && !rd_flushed && !rd_empty;
    // A full channel can still accept a push if it pops in the same cycle.
    push_ok    = wr_en && !wr_flushed &&
                 (!wr_full || (pop_ok && (rd_ch == wr_ch)));
    ovf_ev[wr_ch] = wr_en && !wr_flushed && !push_ok;
    // An empty channel has nothing to read; a same-cycle push is not bypassed.
    unf_ev[rd_ch] = rd_en && !rd_flushed && rd_empty;
  end

  // Per-channel pointer and occupancy next state.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wptr_d[c]  = wptr_q[c];
      rptr_d[c]  = rptr_q[c];
      count_d[c] = count_q[c];
      if (flush && (flush_ch == CHW'(c))) begin
        wptr_d[c]  = '0;
        rptr_d[c]  = '0;
        count_d[c] = '0;
      end else begin
        if (push_ok && (wr_ch == CHW'(c))) wptr_d[c] = wptr_q[c] + AW'(1);
        if (pop_ok  && (rd_ch == CHW'(c))) rptr_d[c] = rptr_q[c] + AW'(1);
        case ({push_ok && (wr_ch == CHW'(c)), pop_ok && (rd_ch == CHW'(c))})
          2'b10:   count_d[c] = count_q[c] + (AW+1)'(1);
          2'b01:   count_d[c] = count_q[c] - (AW+1)'(1);
          default: count_d[c] = count_q[c];
        endcase
      end
    end
  end

  // Sticky flags: a new event in the clearing cycle survives the clear.
  always_comb begin
    ovf_d = clr_err ? ovf_ev : (ovf_q | ovf_ev);
    unf_d = clr_err ? unf_ev : (unf_q | unf_ev);
  end

  // Control state and the registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
      end
      ovf_q      <= '0;
      unf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers then
      // update together, and the read below sees the memory before this
      // edge's write.
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= pop_ok;
      if (pop_ok) rd_data_q <= mem_q[{rd_ch, rptr_q[rd_ch]}];
    end
  end

  // Storage write port.
  // NOTE: the memory array is deliberately not reset. The counts alone
  // decide what is valid, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[{wr_ch, wptr_q[wr_ch]}] <= wr_data;
  end

  // Status decode, taken combinationally from the counts.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      full[c]  = (count_q[c] == FULL_CNT);
      empty[c] = (count_q[c] == '0);
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_crc_fifo_buffer.sv
// Self-checking bench for crc_fifo_buffer. A queue-per-channel reference
// model is checked on every falling edge. Directed scenarios pin the model
// with literal expectations, and a randomized phase follows.
module tb_crc_fifo_buffer;

  localparam int CW = 32, NCH = 4, CHW = 2, DEPTH = 16, AW = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [CW-1:0]  wr_data = '0;
  logic           rd_en = 1'b0;
  logic [CHW-1:0] rd_ch = '0;
  logic [CW-1:0]  rd_data;
  logic           rd_valid;
  logic           flush = 1'b0;
  logic [CHW-1:0] flush_ch = '0;
  logic           clr_err = 1'b0;
  logic [NCH-1:0] full, empty, overflow, underflow;

  int vectors = 0;
  int miscompares = 0;

  crc_fifo_buffer #(.CW(CW), .NCH(NCH), .CHW(CHW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .flush_ch(flush_ch), .clr_err(clr_err),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one queue per channel plus the flag and read registers.
  logic [CW-1:0]  mq [NCH][$];
  logic [NCH-1:0] m_ovf = '0, m_unf = '0, ev_ovf, ev_unf;
  logic [CW-1:0]  m_rd_data = '0;
  logic           m_rd_valid = 1'b0;
  bit             m_pop, m_push, m_rfl, m_wfl;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_ovf = '0; m_unf = '0; m_rd_data = '0; m_rd_valid = 1'b0;
    end else begin
      ev_ovf = '0; ev_unf = '0;
      m_rfl  = flush && (flush_ch == rd_ch);
      m_wfl  = flush && (flush_ch == wr_ch);
      m_pop  = rd_en && !m_rfl && (mq[rd_ch].size() != 0);
      if (rd_en && !m_rfl && (mq[rd_ch].size() == 0)) ev_unf[rd_ch] = 1'b1;
      m_push = 1'b0;
      if (wr_en && !m_wfl) begin
        if (mq[wr_ch].size() < DEPTH || (m_pop && rd_ch == wr_ch)) m_push = 1'b1;
        else ev_ovf[wr_ch] = 1'b1;
      end
      if (m_pop) m_rd_data = mq[rd_ch].pop_front();
      m_rd_valid = m_pop;
      if (m_push) mq[wr_ch].push_back(wr_data);
      if (flush) mq[flush_ch].delete();
      m_ovf = clr_err ? ev_ovf : (m_ovf | ev_ovf);
      m_unf = clr_err ? ev_unf : (m_unf | ev_unf);
    end
  end

  // Compare process: outputs are settled mid-cycle.
  logic [NCH-1:0] m_full, m_empty;
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_full[c]  = (mq[c].size() == DEPTH);
        m_empty[c] = (mq[c].size() == 0);
      end
      check("rd_valid",  rd_valid,  m_rd_valid);
      check("rd_data",   rd_data,   m_rd_data);
      check("full",      full,      m_full);
      check("empty",     empty,     m_empty);
      check("overflow",  overflow,  m_ovf);
      check("underflow", underflow, m_unf);
    end
  end

  // One clock of stimulus. It returns just after the edge, with inputs idle.
  task automatic op(input bit we, input int wch, input logic [CW-1:0] wd,
                    input bit re, input int rch,
                    input bit fl = 1'b0, input int fch = 0, input bit ce = 1'b0);
    wr_en = we; wr_ch = CHW'(wch); wr_data = wd;
    rd_en = re; rd_ch = CHW'(rch);
    flush = fl; flush_ch = CHW'(fch); clr_err = ce;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_rd_data",  rd_data,  32'h0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_full",     full,     4'h0);
    check("rst_empty",    empty,    4'hF);
    check("rst_flags",    {overflow, underflow}, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;

    // Ordered pops on channel 1
    for (int i = 1; i <= 3; i++) op(1, 1, 32'hA000_0000 + CW'(i), 0, 0);
    for (int i = 1; i <= 3; i++) begin
      op(0, 0, 0, 1, 1);
      check("t1_valid", rd_valid, 1'b1);
      check("t1_data",  rd_data,  32'hA000_0000 + 64'(i));
    end
    check("t1_empty1", empty[1], 1'b1);

    // Overflow on a full channel 0
    for (int i = 0; i < DEPTH; i++) op(1, 0, 32'hB000_0000 + CW'(i), 0, 0);
    op(1, 0, 32'h0000_DEAD, 0, 0);
    check("t2_full0", full[0],     1'b1);
    check("t2_ovf0",  overflow[0], 1'b1);
    op(0, 0, 0, 0, 0, 0, 0, 1);
    check("t2_clr",   overflow,    4'h0);
    for (int i = 0; i < DEPTH; i++) op(0, 0, 0, 1, 0);
    check("t2_last",  rd_data,     32'hB000_000F);

    // Push and pop together on a full channel 2, then wrap around
    for (int i = 0; i < DEPTH; i++) op(1, 2, 32'hC000_0000 + CW'(i), 0, 0);
    op(1, 2, 32'h55, 1, 2);
    check("t3_oldest", rd_data, 32'hC000_0000);
    check("t3_full2",  full[2], 1'b1);
    for (int i = 0; i < 20; i++) begin
      op(1, 2, 32'hD000_0000 + CW'(i), 1, 2);
      if (i == 15) check("t3_55_last", rd_data, 32'h55);
    end
    for (int i = 0; i < DEPTH; i++) op(0, 0, 0, 1, 2);
    check("t3_drained", rd_data, 32'hD000_0013);

    // Pop on empty channel 3 with a same-cycle push
    op(1, 3, 32'h77, 1, 3);
    check("t4_novalid", rd_valid,     1'b0);
    check("t4_unf3",    underflow[3], 1'b1);
    op(0, 0, 0, 1, 3, 0, 0, 1);
    check("t4_data",    rd_data,      32'h77);
    check("t4_valid",   rd_valid,     1'b1);

    // Flush channel 0 while channel 1 holds data
    for (int i = 0; i < 4; i++) begin
      op(1, 0, 32'hE0 + CW'(i), 0, 0);
      op(1, 1, 32'hF0 + CW'(i), 0, 0);
    end
    op(1, 0, 32'h99, 0, 0, 1, 0);
    check("t5_empty0", empty[0], 1'b1);
    check("t5_flags",  {overflow, underflow}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      op(0, 0, 0, 1, 1);
      check("t5_ch1", rd_data, 32'hF0 + 64'(i));
    end

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++)
      op($urandom_range(0, 99) < 65, $urandom_range(0, NCH-1), $urandom,
         $urandom_range(0, 99) < 45, $urandom_range(0, NCH-1),
         $urandom_range(0, 99) < 3, $urandom_range(0, NCH-1),
         $urandom_range(0, 99) < 3);

    // Asynchronous reset while channel 0 holds five entries and a pop is pending
    for (int c = 0; c < NCH; c++) op(0, 0, 0, 0, 0, 1, c, 1);
    for (int i = 0; i < 5; i++) op(1, 0, 32'h6000 + CW'(i), 0, 0);
    rd_en = 1'b1; rd_ch = '0;
    #2 reset = 1'b1;
    #1;
    check("t6_empty",  empty,    4'hF);
    check("t6_full",   full,     4'h0);
    check("t6_valid",  rd_valid, 1'b0);
    check("t6_data",   rd_data,  32'h0);
    check("t6_flags",  {overflow, underflow}, 8'h00);
    @(posedge clk); #1;
    check("t6_valid2", rd_valid, 1'b0);
    rd_en = 1'b0;
    reset = 1'b0;
    op(0, 0, 0, 1, 0);
    check("t6_unf0",   underflow[0], 1'b1);
    check("t6_novalid", rd_valid,    1'b0);
    op(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
